uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive path: oversampled asynchronous serial input to parallel byte. Handles start-bit qualification, LSB-first data sampling, optional parity check and stop-bit check. Sits between the pad-side RX line and the register/FIFO layer. It is the receive counterpart of the existing TX serializer/FSM and uses the same frame format.

Parameters:
WIDTH, 8, data bits per frame
PRESC_W, 6, width of PRESCALE input

Ports:
CLK  input  1  oversampling clock (PRESCALE ticks per bit)
RST  input  1  asynchronous reset, active-low
RX_IN  input  1  serial line, idle high, asynchronous to CLK
PRESCALE  input  PRESC_W  oversample ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries parity bit
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  WIDTH  last good received word
DATA_VALID  output  1  one-cycle pulse, P_DATA updated
PAR_ERR  output  1  one-cycle pulse, parity mismatch
STP_ERR  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset (RST low, any time including mid-frame): FSM -> IDLE, counters 0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, synchronizer flops=1.
- RX_IN passes through a 2-flop synchronizer (reset value 1). All timing below refers to the synchronized signal rx_s.
- PRESCALE, PAR_EN and PAR_TYP are latched on leaving IDLE. Mid-frame changes are ignored. Illegal PRESCALE gives undefined frame results but must not hang the FSM.
- Counters: edge_cnt runs 0..PRESCALE-1 per bit and wraps to 0 at bit end. bit_cnt counts data bits 0..WIDTH-1.
- Sample: the bit value is taken at edge_cnt == PRESCALE/2 and is registered in the cycle after.
- States:
  IDLE: rx_s==0 -> START with edge_cnt=0.
  START: at the sample point, rx_s==1 -> IDLE (glitch; no output, no error). Otherwise stay until the bit ends, then -> DATA.
  DATA: sampled bit shifted into shift register LSB-first. After bit WIDTH-1 ends -> PARITY if PAR_EN, else -> STOP.
  PARITY: expected = ^data (even) or ~^data (odd). Mismatch -> PAR_ERR pulse at bit end; an error flag is held for the frame. -> STOP.
  STOP: sampled 0 -> STP_ERR pulse at bit end. At bit end -> IDLE.
- DATA_VALID: pulses in the cycle after the STOP bit end, only if neither error occurred. P_DATA loads in that same cycle. P_DATA holds its value until the next good frame and is never written on an errored frame.
- Both errors in one frame: both pulses fire at their respective bit ends.
- Back-to-back frames: IDLE re-arms in the cycle after STOP and accepts a start edge immediately. A one-cycle phase slip per frame is acceptable.
- Line held low (break): STP_ERR fires, then the block re-enters START every frame. No DATA_VALID.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined: each bit (start, data, parity, stop) is the 2-of-3 majority of rx_s at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The decision is registered at PRESCALE/2+2.
- Undefined: single sample at PRESCALE/2, as above.
- Frame-level latency of DATA_VALID is identical in both builds, since it is always tied to STOP bit end.

Decomposition:
- Shared header/package (uart_defs): WIDTH default, FSM state encodings (IDLE, START, DATA, PARITY, STOP), legal PRESCALE constants. TX and RX both include it.
- One natural sub-module: uart_rx_sampler. It holds edge_cnt and the sample/majority logic and outputs sampled_bit, sample_strobe and bit_end.
- FSM, shift register, parity and stop checks stay in uart_rx.

Test Plan:
- PRESCALE=8, PAR_EN=0, send 0xA5 with stop=1 -> one DATA_VALID pulse, P_DATA=0xA5, no error pulses.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity=0 -> DATA_VALID, P_DATA=0x3C. Resend with parity=1 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0x3C.
- PRESCALE=8, send 0x81 with stop=0 -> STP_ERR pulse, no DATA_VALID. A following good 0x42 frame -> DATA_VALID, P_DATA=0x42.
- RX_IN low for 2 cycles (PRESCALE=8), then high -> FSM back to IDLE, no outputs. A subsequent valid 0x11 frame is received correctly.
- Majority test, PRESCALE=16: a 1-cycle inverted glitch at edge_cnt=8 of data bit 3 while sending 0x55. With RX_MAJORITY_VOTE_EN -> P_DATA=0x55. Without -> P_DATA=0x5D.
- Assert RST low during data bit 4 of 0xF0 -> all outputs 0 immediately, no pulses. After release, a full 0x0F frame -> P_DATA=0x0F.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions for the TX and RX paths: default frame width,
// FSM state encoding, legal oversample ratios and the 2-of-3 vote helper.
package uart_defs_pkg;

  localparam int UART_WIDTH   = 8;
  localparam int UART_PRESC_W = 6;

  localparam logic [5:0] PRESCALE_X8  = 6'd8;
  localparam logic [5:0] PRESCALE_X16 = 6'd16;
  localparam logic [5:0] PRESCALE_X32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling timer and bit decision for the UART receiver.
// With RX_MAJORITY_VOTE_EN defined the bit is a 2-of-3 vote around mid-bit.
module uart_rx_sampler
  import uart_defs_pkg::*;
#(
  parameter int PRESC_W = UART_PRESC_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_rx_s,
  input  logic               i_active,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_sampled_bit,
  output logic               o_sample_strobe,
  output logic               o_bit_end
);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [PRESC_W-1:0] w_half;
  logic [PRESC_W-1:0] w_last;

  assign w_half    = i_prescale >> 1;
  assign w_last    = i_prescale - PRESC_W'(1);
  assign o_bit_end = i_active & (r_edge_cnt == w_last);

  // Oversample counter: parked at 0 while idle, wraps at the end of every bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
    end else if (!i_active || o_bit_end) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic               r_smp_a;
  logic               r_smp_b;
  logic [PRESC_W-1:0] w_pt_a;
  logic [PRESC_W-1:0] w_pt_c;
  logic [PRESC_W-1:0] w_pt_done;

  assign w_pt_a          = w_half - PRESC_W'(1);
  assign w_pt_c          = w_half + PRESC_W'(1);
  assign w_pt_done       = w_half + PRESC_W'(2);
  assign o_sample_strobe = i_active & (r_edge_cnt == w_pt_done);

  // Capture the two early samples, then register the vote with the third.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_smp_a       <= 1'b1;
      r_smp_b       <= 1'b1;
      o_sampled_bit <= 1'b1;
    end else begin
      if (r_edge_cnt == w_pt_a) r_smp_a <= i_rx_s;
      if (r_edge_cnt == w_half) r_smp_b <= i_rx_s;
      if (r_edge_cnt == w_pt_c) o_sampled_bit <= majority3(r_smp_a, r_smp_b, i_rx_s);
    end
  end
`else
  logic [PRESC_W-1:0] w_pt_done;

  assign w_pt_done       = w_half + PRESC_W'(1);
  assign o_sample_strobe = i_active & (r_edge_cnt == w_pt_done);

  // Single mid-bit sample, valid from the following cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_sampled_bit <= 1'b1;
    end else if (r_edge_cnt == w_half) begin
      o_sampled_bit <= i_rx_s;
    end else begin
      o_sampled_bit <= o_sampled_bit;
    end
  end
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, LSB-first shift register, parity
// and stop checks. Optional majority voting via RX_MAJORITY_VOTE_EN.
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int WIDTH   = UART_WIDTH,
  parameter int PRESC_W = UART_PRESC_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [WIDTH-1:0]   P_DATA,
  output logic               DATA_VALID,
  output logic               PAR_ERR,
  output logic               STP_ERR
);

  localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  uart_state_e        r_state;
  uart_state_e        w_state_nxt;
  logic               r_sync1;
  logic               r_rx_s;
  logic [PRESC_W-1:0] r_presc;
  logic               r_par_en;
  logic               r_par_typ;
  logic [BCW-1:0]     r_bit_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic               r_par_bad;
  logic               r_stp_bad;
  logic               w_active;
  logic               w_sampled;
  logic               w_strobe;
  logic               w_bit_end;
  logic               w_leave_idle;
  logic               w_stop_end;
  logic               w_par_exp;

  function automatic logic calc_parity(input logic [WIDTH-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

  assign w_active  = (r_state != ST_IDLE);
  assign w_par_exp = calc_parity(r_shift, r_par_typ);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_rx_s  <= r_sync1;
    end
  end

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK             (CLK),
    .RST             (RST),
    .i_rx_s          (r_rx_s),
    .i_active        (w_active),
    .i_prescale      (r_presc),
    .o_sampled_bit   (w_sampled),
    .o_sample_strobe (w_strobe),
    .o_bit_end       (w_bit_end)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and frame-event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_leave_idle = 1'b0;
    w_stop_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt  = ST_START;
          w_leave_idle = 1'b1;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_strobe && w_sampled) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          w_stop_end  = 1'b1;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame datapath; config and error flags are frozen for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc   <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_stp_bad <= 1'b0;
    end else if (w_leave_idle) begin
      r_presc   <= PRESCALE;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
      r_bit_cnt <= '0;
      r_par_bad <= 1'b0;
      r_stp_bad <= 1'b0;
    end else begin
      if ((r_state == ST_DATA) && w_strobe) r_shift <= {w_sampled, r_shift[WIDTH-1:1]};
      if ((r_state == ST_DATA) && w_bit_end) begin
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BCW'(1);
      end
      if ((r_state == ST_PARITY) && w_strobe) r_par_bad <= (w_sampled != w_par_exp);
      if ((r_state == ST_STOP) && w_strobe) r_stp_bad <= ~w_sampled;
    end
  end

  // Registered outputs: pulses land in the cycle after the relevant bit end.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      PAR_ERR    <= (r_state == ST_PARITY) && w_bit_end && r_par_bad;
      STP_ERR    <= w_stop_end && r_stp_bad;
      DATA_VALID <= w_stop_end && !r_par_bad && !r_stp_bad;
      if (w_stop_end && !r_par_bad && !r_stp_bad) P_DATA <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int total = 0;
  int bad   = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  logic [7:0] m_pdata;

  uart_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (DATA_VALID) dv_cnt++;
    if (PAR_ERR)    pe_cnt++;
    if (STP_ERR)    se_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    int         presc;
    bit         par_en;
    bit         par_typ;
    bit         flip;
    bit         stop;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives up to 'limit' bits of a frame; gbit/goff place a one-cycle inversion.
  task automatic drive_frame(input logic [7:0] d, input int presc, input bit pen,
                             input bit ptyp, input bit flip, input bit stop,
                             input int gbit, input int goff, input int limit,
                             input bit scramble);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ ptyp ^ flip);
    bits.push_back(stop);
    PRESCALE = 6'(presc);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int b = 0; b < bits.size() && b < limit; b++) begin
      for (int c = 0; c < presc; c++) begin
        RX_IN = (b == gbit && c == goff) ? ~bits[b] : bits[b];
        tick(1);
      end
      if (scramble && b == 1) begin
        PRESCALE = 6'(8 << $urandom_range(0, 2));
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic verify(input string tag, input int dv0, input int pe0, input int se0,
                        input int edv, input int epe, input int ese, input logic [7:0] epd);
    check({tag, "/dv"}, dv_cnt - dv0, edv);
    check({tag, "/par_err"}, pe_cnt - pe0, epe);
    check({tag, "/stp_err"}, se_cnt - se0, ese);
    check({tag, "/p_data"}, int'(P_DATA), int'(epd));
  endtask

  task automatic frame_test(input string tag, input logic [7:0] d, input int presc,
                            input bit pen, input bit ptyp, input bit flip, input bit stop,
                            input int gbit, input int goff, input logic [7:0] epd);
    int dv0, pe0, se0, edv, epe, ese;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    drive_frame(d, presc, pen, ptyp, flip, stop, gbit, goff, 99, 1'b0);
    tick(2 * presc + 8);
    epe = (pen && flip) ? 1 : 0;
    ese = stop ? 0 : 1;
    edv = (epe == 0 && ese == 0) ? 1 : 0;
    verify(tag, dv0, pe0, se0, edv, epe, ese, epd);
  endtask

  initial begin
    int dv0, pe0, se0;
    bit got;
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    tick(4);
    check("reset/p_data", int'(P_DATA), 0);
    check("reset/dv", int'(DATA_VALID), 0);
    check("reset/par_err", int'(PAR_ERR), 0);
    check("reset/stp_err", int'(STP_ERR), 0);
    @(negedge CLK); RST = 1'b1;
    tick(4);

    vecs[0] = '{8'hA5, 8,  1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
    vecs[2] = '{8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
    vecs[3] = '{8'h81, 8,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
    vecs[4] = '{8'h42, 8,  1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h42};
    vecs[5] = '{8'h96, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h96};
    vecs[6] = '{8'h07, 16, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 8'h96};
    for (int i = 0; i < 7; i++) begin
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      drive_frame(vecs[i].data, vecs[i].presc, vecs[i].par_en, vecs[i].par_typ,
                  vecs[i].flip, vecs[i].stop, -1, 0, 99, 1'b0);
      tick(2 * vecs[i].presc + 8);
      verify($sformatf("vec%0d", i), dv0, pe0, se0,
             vecs[i].exp_dv, vecs[i].exp_pe, vecs[i].exp_se, vecs[i].exp_pdata);
    end
    m_pdata = 8'h96;

    // Two-cycle start glitch must be rejected silently.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0; tick(2); RX_IN = 1'b1; tick(40);
    verify("start_glitch", dv0, pe0, se0, 0, 0, 0, m_pdata);
    m_pdata = 8'h11;
    frame_test("after_glitch", 8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, m_pdata);

    // One-cycle inversion at mid-point of data bit 3 (frame bit 4).
`ifdef RX_MAJORITY_VOTE_EN
    m_pdata = 8'h55;
`else
    m_pdata = 8'h5D;
`endif
    frame_test("majority", 8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4, 9, m_pdata);

    // Break: line held low until the first stop error, then released.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge CLK);
      if (STP_ERR) got = 1'b1;
    end
    RX_IN = 1'b1;
    check("break/stp_seen", int'(got), 1);
    tick(40);
    verify("break", dv0, pe0, se0, 0, 0, 1, m_pdata);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    drive_frame(8'hE1, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 99, 1'b0);
    drive_frame(8'h2B, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 99, 1'b0);
    tick(48);
    m_pdata = 8'h2B;
    verify("b2b", dv0, pe0, se0, 2, 0, 0, m_pdata);

    // Random frames with mid-frame config scrambling, against the model.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      int presc, epe, ese;
      bit pen, ptyp, flip, stop;
      d     = 8'($urandom);
      presc = 8 << $urandom_range(0, 2);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      flip  = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 4) != 0);
      epe   = (pen && flip) ? 1 : 0;
      ese   = stop ? 0 : 1;
      if (epe == 0 && ese == 0) m_pdata = d;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      drive_frame(d, presc, pen, ptyp, flip, stop, -1, 0, 99, 1'b1);
      tick(2 * presc + 8);
      verify($sformatf("rnd%0d", n), dv0, pe0, se0,
             (epe == 0 && ese == 0) ? 1 : 0, epe, ese, m_pdata);
    end

    // Reset in the middle of data bit 4 of 0xF0.
    frame_test("pre_reset", 8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 8'hC3);
    drive_frame(8'hF0, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 6, 1'b0);
    RX_IN = 1'b1;
    RST = 1'b0;
    #1;
    check("midreset/p_data", int'(P_DATA), 0);
    check("midreset/dv", int'(DATA_VALID), 0);
    check("midreset/par_err", int'(PAR_ERR), 0);
    check("midreset/stp_err", int'(STP_ERR), 0);
    tick(3);
    @(negedge CLK); RST = 1'b1;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    tick(80);
    verify("post_reset_quiet", dv0, pe0, se0, 0, 0, 0, 8'h00);
    frame_test("post_reset", 8'h0F, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
